// File: rtl/sw_broadcast_arbiter.sv
// sw_broadcast_arbiter
// Shares the single store-broadcast bus between N_CORE child cores in
// parallel mode. Each core's committed stores land in a small private FIFO.
// A round-robin arbiter then picks at most one head entry per cycle and
// places it on a registered broadcast bus that feeds every core's data
// memory write port. The drained flag is the end-of-parallel-section
// barrier condition: nothing queued and nothing on the bus.

module sw_broadcast_arbiter #(
   parameter int N_CORE     = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_CORE-1:0]            req_valid,
   output logic [N_CORE-1:0]            req_ready,
   input  logic [N_CORE*ADDR_WIDTH-1:0] req_addr,
   input  logic [N_CORE*32-1:0]         req_data,
   input  logic                         hold,
   output logic                         bcast_valid,
   output logic [ADDR_WIDTH-1:0]        bcast_addr,
   output logic [31:0]                  bcast_data,
   output logic [$clog2(N_CORE)-1:0]    bcast_src,
   output logic                         drained
);

   localparam int SRC_W = $clog2(N_CORE);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Per-core FIFO bookkeeping. Pointers are exactly PTR_W bits so they wrap
   // on their own; count needs one extra bit to represent "full".
   logic [CNT_W-1:0]      count  [N_CORE];
   logic [PTR_W-1:0]      wr_ptr [N_CORE];
   logic [PTR_W-1:0]      rd_ptr [N_CORE];

   // Entry storage. Contents need no reset: count decides what is valid.
   logic [ADDR_WIDTH-1:0] fifo_addr [N_CORE][FIFO_DEPTH];
   logic [31:0]           fifo_data [N_CORE][FIFO_DEPTH];

   // Head-of-FIFO view for every core, used by the output register.
   logic [ADDR_WIDTH-1:0] head_addr [N_CORE];
   logic [31:0]           head_data [N_CORE];

   // Round-robin pointer: the core that gets first look next cycle.
   logic [SRC_W-1:0]      rr_ptr;

   // Arbitration result for the current cycle.
   logic                  grant_valid;
   logic [SRC_W-1:0]      grant_idx;

   logic [N_CORE-1:0]     push;
   logic [N_CORE-1:0]     pop;

   // Expose each FIFO's head entry so the winner can be copied onto the bus.
   always_comb begin
      for (int i = 0; i < N_CORE; i++) begin
         head_addr[i] = fifo_addr[i][rd_ptr[i]];
         head_data[i] = fifo_data[i][rd_ptr[i]];
      end
   end

   // Round-robin scan starting at rr_ptr; first non-empty FIFO wins, and
   // hold (parent owns the bus) suppresses the grant without moving rr_ptr.
   always_comb begin
      logic [SRC_W:0]   scan;
      logic [SRC_W-1:0] cand;
      grant_valid = 1'b0;
      grant_idx   = '0;
      scan        = '0;
      cand        = '0;
      for (int k = 0; k < N_CORE; k++) begin
         scan = {1'b0, rr_ptr} + (SRC_W+1)'(k);
         if (scan >= (SRC_W+1)'(N_CORE)) begin
            scan = scan - (SRC_W+1)'(N_CORE);
         end
         cand = scan[SRC_W-1:0];
         if (!grant_valid && (count[cand] != '0)) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
      if (hold) begin
         grant_valid = 1'b0;
      end
   end

   // One-hot pop of the granted core's FIFO head.
   always_comb begin
      pop = '0;
      if (grant_valid) begin
         pop[grant_idx] = 1'b1;
      end
   end

   // A slot is available if the FIFO is not full or its head leaves this
   // cycle; ready deliberately ignores req_valid to avoid a comb loop.
   always_comb begin
      for (int i = 0; i < N_CORE; i++) begin
         req_ready[i] = (count[i] < CNT_W'(FIFO_DEPTH)) || pop[i];
      end
      push = req_valid & req_ready;
   end

   // FIFO pointers and occupancy; push and pop together leave count alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_CORE; i++) begin
            count[i]  <= '0;
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CORE; i++) begin
            if (push[i]) begin
               wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
            end
            if (pop[i]) begin
               rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
            end
            if (push[i] && !pop[i]) begin
               count[i] <= count[i] + CNT_W'(1);
            end else if (pop[i] && !push[i]) begin
               count[i] <= count[i] - CNT_W'(1);
            end
         end
      end
   end

   // Write accepted stores into the slot at each core's write pointer.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_CORE; i++) begin
         if (push[i]) begin
            fifo_addr[i][wr_ptr[i]] <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            fifo_data[i][wr_ptr[i]] <= req_data[i*32 +: 32];
         end
      end
   end

   // Register the winning entry onto the broadcast bus and advance rr_ptr
   // past the winner; payload and rr_ptr hold when nothing is granted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bcast_valid <= 1'b0;
         bcast_addr  <= '0;
         bcast_data  <= '0;
         bcast_src   <= '0;
         rr_ptr      <= '0;
      end else begin
         bcast_valid <= grant_valid;
         if (grant_valid) begin
            bcast_addr <= head_addr[grant_idx];
            bcast_data <= head_data[grant_idx];
            bcast_src  <= grant_idx;
            if (grant_idx == SRC_W'(N_CORE - 1)) begin
               rr_ptr <= '0;
            end else begin
               rr_ptr <= grant_idx + SRC_W'(1);
            end
         end
      end
   end

   // Barrier condition: every FIFO empty and no broadcast on the bus.
   always_comb begin
      drained = !bcast_valid;
      for (int i = 0; i < N_CORE; i++) begin
         if (count[i] != '0) begin
            drained = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sw_broadcast_arbiter.sv
// tb_sw_broadcast_arbiter
// Drives directed and randomized store traffic into sw_broadcast_arbiter and
// compares every output each cycle against a queue-based reference model of
// the store broadcast bus.

module tb_sw_broadcast_arbiter;

   localparam int N     = 4;
   localparam int AW    = 16;
   localparam int DEPTH = 2;
   localparam int SW    = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_addr;
   logic [N*32-1:0] req_data;
   logic            hold;
   logic            bcast_valid;
   logic [AW-1:0]   bcast_addr;
   logic [31:0]     bcast_data;
   logic [SW-1:0]   bcast_src;
   logic            drained;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } entry_t;

   // Reference model: one queue per core, the rotating priority and the
   // registered broadcast bus contents.
   entry_t        mq [N][$];
   int            mrr;
   logic          m_bv;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_data;
   logic [SW-1:0] m_src;

   sw_broadcast_arbiter #(
      .N_CORE    (N),
      .ADDR_WIDTH(AW),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .hold       (hold),
      .bcast_valid(bcast_valid),
      .bcast_addr (bcast_addr),
      .bcast_data (bcast_data),
      .bcast_src  (bcast_src),
      .drained    (drained)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < N; i++) mq[i].delete();
      mrr    = 0;
      m_bv   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_src  = '0;
   endtask

   task automatic checkResetOutputs();
      checkOutput("rst_bcast_valid", 64'(bcast_valid), 64'(0));
      checkOutput("rst_bcast_addr",  64'(bcast_addr),  64'(0));
      checkOutput("rst_bcast_data",  64'(bcast_data),  64'(0));
      checkOutput("rst_bcast_src",   64'(bcast_src),   64'(0));
      checkOutput("rst_drained",     64'(drained),     64'(1));
      checkOutput("rst_req_ready",   64'(req_ready),   64'(4'b1111));
   endtask

   // One clock cycle: drive inputs, check outputs against the model, then
   // advance the model across the clock edge.
   task automatic applyStimulus(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                                input logic [N*32-1:0] d, input logic h);
      int           g;
      int           c;
      logic [N-1:0] expReady;
      logic         expDrained;
      entry_t       e;
      @(negedge clk);
      req_valid = v;
      req_addr  = a;
      req_data  = d;
      hold      = h;
      #1;
      g = -1;
      if (!h) begin
         for (int k = 0; k < N; k++) begin
            c = (mrr + k) % N;
            if (g < 0 && mq[c].size() != 0) g = c;
         end
      end
      expDrained = !m_bv;
      for (int i = 0; i < N; i++) begin
         expReady[i] = (mq[i].size() < DEPTH) || (g == i);
         if (mq[i].size() != 0) expDrained = 1'b0;
      end
      checkOutput("req_ready",   64'(req_ready),   64'(expReady));
      checkOutput("bcast_valid", 64'(bcast_valid), 64'(m_bv));
      checkOutput("bcast_addr",  64'(bcast_addr),  64'(m_addr));
      checkOutput("bcast_data",  64'(bcast_data),  64'(m_data));
      checkOutput("bcast_src",   64'(bcast_src),   64'(m_src));
      checkOutput("drained",     64'(drained),     64'(expDrained));
      @(posedge clk);
      if (g >= 0) begin
         e      = mq[g].pop_front();
         m_bv   = 1'b1;
         m_addr = e.addr;
         m_data = e.data;
         m_src  = SW'(g);
         mrr    = (g + 1) % N;
      end else begin
         m_bv = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         if (v[i] && expReady[i]) begin
            e.addr = a[i*AW +: AW];
            e.data = d[i*32 +: 32];
            mq[i].push_back(e);
         end
      end
   endtask

   task automatic idleCycles(input int n);
      for (int c = 0; c < n; c++) applyStimulus('0, '0, '0, 1'b0);
   endtask

   task automatic randomCycles(input int n, input int validPct, input int holdPct);
      logic [N-1:0]    v;
      logic [N*AW-1:0] a;
      logic [N*32-1:0] d;
      logic            h;
      for (int c = 0; c < n; c++) begin
         for (int i = 0; i < N; i++) begin
            v[i]          = ($urandom_range(99) < validPct);
            a[i*AW +: AW] = AW'($urandom);
            d[i*32 +: 32] = $urandom;
         end
         h = ($urandom_range(99) < holdPct);
         applyStimulus(v, a, d, h);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkResetOutputs();
      modelReset();
      req_valid = '0;
      hold      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Test sequence: reset, directed scenarios, randomized traffic, reset
   // mid-stream, final drain.
   initial begin
      logic [N*AW-1:0] a;
      logic [N*32-1:0] d;
      reset     = 1'b1;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      hold      = 1'b0;
      modelReset();
      #2;
      checkResetOutputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Single store from core 2.
      a = '0;
      d = '0;
      a[2*AW +: AW] = 16'h0010;
      d[2*32 +: 32] = 32'hDEADBEEF;
      applyStimulus(4'b0100, a, d, 1'b0);
      idleCycles(4);

      // All cores push in the same cycle.
      for (int i = 0; i < N; i++) begin
         a[i*AW +: AW] = AW'(16'h0100 + i);
         d[i*32 +: 32] = 32'hA0000000 + i;
      end
      applyStimulus(4'b1111, a, d, 1'b0);
      idleCycles(6);

      // Core 1 fills its FIFO under hold, then hold is released.
      for (int s = 0; s < 3; s++) begin
         a[1*AW +: AW] = AW'(16'h0200 + s);
         d[1*32 +: 32] = 32'hB0000000 + s;
         applyStimulus(4'b0010, a, d, 1'b1);
      end
      applyStimulus(4'b0010, a, d, 1'b0);
      idleCycles(5);

      // Core 0 saturates while core 3 has one store pending.
      a[3*AW +: AW] = 16'h0333;
      d[3*32 +: 32] = 32'hC0000003;
      a[0]          = 1'b0;
      applyStimulus(4'b1001, a, d, 1'b0);
      for (int s = 0; s < 8; s++) begin
         a[0*AW +: AW] = AW'(16'h0400 + s);
         d[0*32 +: 32] = 32'hD0000000 + s;
         applyStimulus(4'b0001, a, d, 1'b0);
      end
      idleCycles(4);

      // Single-cycle hold bubble mid-stream.
      randomCycles(6, 70, 0);
      applyStimulus('0, '0, '0, 1'b1);
      idleCycles(10);

      // Randomized traffic: light, heavy, and hold-dominated.
      randomCycles(200, 30, 10);
      randomCycles(200, 90, 15);
      randomCycles(150, 80, 50);

      // Reset while entries are queued and the bus is busy.
      randomCycles(8, 100, 0);
      doReset();
      a = '0;
      d = '0;
      a[3*AW +: AW] = 16'h0077;
      d[3*32 +: 32] = 32'h12345678;
      applyStimulus(4'b1000, a, d, 1'b0);
      idleCycles(4);

      randomCycles(100, 60, 20);
      idleCycles(12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sw_broadcast_arbiter.md
Name: sw_broadcast_arbiter

Overview:
Shares the single store-broadcast bus between N_CORE child cores when they run in parallel mode. Each core's committed stores (address, data) enter a small per-core FIFO. A round-robin arbiter then emits at most one store per cycle on a registered broadcast bus that feeds every core's data-memory write port. The block also reports when all pending stores have been broadcast, which is used as the barrier condition at the end of a parallel section.

Parameters:
N_CORE, 4, number of requesting cores (>=2)
ADDR_WIDTH, 16, store address width (matches DATA_MEM_WIDTH)
FIFO_DEPTH, 2, entries per core FIFO (power of two, >=2)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req_valid  input  N_CORE  core i has a committed store to broadcast
req_ready  output  N_CORE  core i's store is accepted this cycle if valid&&ready
req_addr  input  N_CORE*ADDR_WIDTH  store address, core i in slice i
req_data  input  N_CORE*32  store data, core i in slice i
hold  input  1  suppress grants (parent owns the bus in serial mode)
bcast_valid  output  1  broadcast store present this cycle
bcast_addr  output  ADDR_WIDTH  broadcast address
bcast_data  output  32  broadcast data
bcast_src  output  $clog2(N_CORE)  originating core of the broadcast
drained  output  1  all FIFOs empty and bcast_valid low

Behaviour:
- Reset is asynchronous, active-high. On reset:
  - all FIFO counts, read/write pointers and rr_ptr go to 0
  - bcast_valid=0, bcast_addr=0, bcast_data=0, bcast_src=0
  - drained=1, req_ready all 1
  - any entries held in the FIFOs at reset are discarded.
- Enqueue:
  - req_ready[i] = count[i]<FIFO_DEPTH || pop[i] (same-cycle pop frees a slot). It is combinational and never depends on req_valid.
  - On valid&&ready the entry is written at the clock edge. Simultaneous push and pop on one core leaves its count unchanged.
- Arbitration (combinational, in cycle t):
  - Candidates are the cores with count[i]!=0, scanned in order rr_ptr, rr_ptr+1, ... modulo N_CORE.
  - The first candidate found is granted; pop[grant]=1.
  - If hold=1 or there are no candidates, nothing is popped.
- Output register (edge ending cycle t):
  - bcast_valid <= any grant.
  - bcast_addr, bcast_data, bcast_src <= the granted entry's fields. These update only on a grant and otherwise hold their last value.
  - rr_ptr <= grant+1 (mod N_CORE), updated only on a grant.
- Latency: a store accepted at the edge ending cycle t is broadcast (bcast_valid=1) in cycle t+2 at the earliest, assuming no contention and hold=0.
- Throughput: 1 broadcast per cycle total. Per-core order is preserved (FIFO).
- Fairness: any non-empty core is granted within N_CORE cycles while hold=0.
- hold:
  - Asserted in cycle t: bcast_valid=0 in cycle t+1.
  - Enqueue continues until the FIFOs fill; ready then drops.
  - Deasserted: arbitration resumes from the unchanged rr_ptr.
- drained = (all count==0) && !bcast_valid, combinational from state. It does not look at req_valid; the parent gates it with core sw_empty.
- Wrap-around: FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Count is $clog2(FIFO_DEPTH)+1 bits.
- Reset asserted mid-operation takes effect immediately (asynchronous). Broadcasts in flight are lost; this is legal because reset also restarts the cores.

Test Plan:
- Reset, then a single push from core 2 (addr=0x0010, data=0xDEADBEEF) in cycle 0 -> bcast_valid=1 in cycle 2 with addr 0x0010, data 0xDEADBEEF, src 2; drained=1 from cycle 3.
- All 4 cores push one store each in the same cycle, rr_ptr=0 -> broadcasts in 4 consecutive cycles with src order 0,1,2,3; rr_ptr ends at 0.
- Core 1 pushes continuously (3 stores, FIFO_DEPTH=2) with hold=1 -> req_ready[1]=0 after 2 accepts. Releasing hold -> ready rises in the same cycle as the first pop; data is broadcast in push order.
- Core 0 saturates while core 3 has one pending store -> core 3 is granted within 4 cycles, src sequence 0,3,0,...
- hold toggled 1 for one cycle mid-stream -> exactly one bubble on bcast_valid, no loss or duplication; drained stays 0 until the last broadcast cycle has ended.
- Assert reset with 2 entries queued and bcast_valid=1 -> outputs are immediately 0, drained=1, req_ready all 1; a following push broadcasts with src correct and no stale entry.
